// File: rtl/iterative_divider_pkg.sv
// +----------------------------------------------------------------+
// | iterative_divider_pkg: shared widths and FSM state encodings   |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

package iterative_divider_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_PREP = 2'd1,
        DIV_ITER = 2'd2,
        DIV_FIX  = 2'd3
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/iterative_divider_div_step.sv
// +----------------------------------------------------------------+
// | div_step: one restoring shift-subtract step of the divider     |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

module div_step
    import iterative_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] partial_rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] new_rem,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             unused_diff_bit;

    assign shifted = {partial_rem, dividend_bit};

    // Subtract as add of the inverted divisor with carry-in 1; the top bit is the sign.
    assign diff    = {1'b0, shifted} + ~{2'b00, divisor_mag} + (WIDTH+2)'(1);
    assign q_bit   = ~diff[WIDTH+1];

    // A kept remainder is always below the divisor, so it fits in WIDTH bits.
    assign new_rem = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

    assign unused_diff_bit = diff[WIDTH];

endmodule

`default_nettype wire

// File: rtl/iterative_divider.sv
// +----------------------------------------------------------------+
// | iterative_divider: multi-cycle signed/unsigned restoring divide|
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

module iterative_divider
    import iterative_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] count;
    logic             signed_op;
    logic [WIDTH-1:0] dvd_raw;
    logic [WIDTH-1:0] dvs_raw;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] prem;
    logic             q_neg;
    logic             r_neg;
    logic             dvs_zero;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    assign dvs_zero = (dvs_raw == '0);
    assign dvd_neg  = signed_op & dvd_raw[WIDTH-1];
    assign dvs_neg  = signed_op & dvs_raw[WIDTH-1];

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .partial_rem (prem),
        .dividend_bit(work[WIDTH-1]),
        .divisor_mag (dvs_mag),
        .new_rem     (step_rem),
        .q_bit       (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: if (start) state_next = DIV_PREP;
            DIV_PREP: state_next = dvs_zero ? DIV_FIX : DIV_ITER;
            DIV_ITER: if (count == CNT_W'(1)) state_next = DIV_FIX;
            DIV_FIX:  state_next = DIV_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != DIV_IDLE);
    end

    // Datapath: work doubles as dividend magnitude and, bit by bit, the quotient.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            signed_op   <= 1'b0;
            dvd_raw     <= '0;
            dvs_raw     <= '0;
            work        <= '0;
            dvs_mag     <= '0;
            prem        <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            done <= (state == DIV_FIX);
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        signed_op <= is_signed;
                        dvd_raw   <= dividend;
                        dvs_raw   <= divisor;
                    end
                end
                DIV_PREP: begin
                    work    <= dvd_neg ? -dvd_raw : dvd_raw;
                    dvs_mag <= dvs_neg ? -dvs_raw : dvs_raw;
                    q_neg   <= dvd_neg ^ dvs_neg;
                    r_neg   <= dvd_neg;
                    prem    <= '0;
                    count   <= CNT_W'(WIDTH);
                end
                DIV_ITER: begin
                    prem  <= step_rem;
                    work  <= {work[WIDTH-2:0], step_q};
                    count <= count - CNT_W'(1);
                end
                DIV_FIX: begin
                    if (dvs_zero) begin
                        quotient    <= '1;
                        remainder   <= dvd_raw;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= q_neg ? -work : work;
                        remainder   <= r_neg ? -prem : prem;
                        div_by_zero <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_iterative_divider.sv
// +----------------------------------------------------------------+
// | tb_iterative_divider: scoreboard bench for iterative_divider   |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

module tb_iterative_divider;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    iterative_divider #(
        .WIDTH(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start for one cycle; the drive cycle is the latency reference.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input int lat, input bit accept);
        exp_t e;
        @(posedge clk); #1;
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        if (accept) begin
            e.q = eq; e.r = er; e.dz = edz; e.cyc = cyc + lat;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start     = 1'b0;
        dividend  = 32'hDEAD_BEEF;
        divisor   = 32'h0000_0000;
        is_signed = ~s;
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wait_cycles(3);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;

        // Unsigned 100/7 with busy profile over cycles 1..35
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 35, 1'b1);
        for (int i = 1; i <= 35; i++) begin
            check($sformatf("busy_c%0d", i), {31'd0, busy}, (i <= 34) ? 32'd1 : 32'd0);
            wait_cycles(1);
        end

        issue(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 35, 1'b1);
        wait_cycles(36);
        issue(32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0, 35, 1'b1);
        wait_cycles(36);

        issue(32'd55, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd55, 1'b1, 3, 1'b1);
        wait_cycles(4);
        issue(32'd55, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd55, 1'b1, 3, 1'b1);
        wait_cycles(4);

        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 35, 1'b1);
        wait_cycles(36);
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 35, 1'b1);
        wait_cycles(36);
        issue(32'd3, 32'd5, 1'b0, 32'd0, 32'd3, 1'b0, 35, 1'b1);
        wait_cycles(36);

        // Start pulsed at cycle 10 of a running divide must be ignored
        issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 35, 1'b1);
        wait_cycles(8);
        @(posedge clk); #1;
        start = 1'b1; dividend = 32'd7; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_cycles(30);

        // Second start in the done cycle is accepted; old results held meanwhile
        issue(32'd200, 32'd3, 1'b0, 32'd66, 32'd2, 1'b0, 35, 1'b1);
        wait_cycles(33);
        issue(32'h1234_5678, 32'h0000_0100, 1'b0, 32'h0012_3456, 32'h0000_0078, 1'b0, 35, 1'b1);
        wait_cycles(5);
        check("hold_quotient", quotient, 32'd66);
        check("hold_remainder", remainder, 32'd2);
        wait_cycles(32);

        // Reset in cycle 20 of a divide aborts it silently
        issue(32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, 35, 1'b0);
        wait_cycles(19);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", remainder, 32'd0);
        check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        wait_cycles(40);

        issue(32'd81, 32'd9, 1'b0, 32'd9, 32'd0, 1'b0, 35, 1'b1);
        wait_cycles(40);

        check("pending_results", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
